ball_motion_engine: RTL and testbench
=====================================

# ball_motion_engine

Moves the ball in screen coordinates and feeds `ballCollisionEngine`. On each motion tick it steps the ball position one increment in the direction currently reported by the collision engine. One cycle later it issues a single-cycle `ballDirUpdate` strobe so the collision engine evaluates the new position. It also handles the serve, where the ball rides on the paddle until launch, and the terminal freeze when the collision engine reports a lost ball.

## Interface
Parameters:
- `TICK_DIV`, 250000: clk cycles between position steps; legal range 4..2^20-1.
- `STEP`, 2: pixels moved per axis per tick; legal range 1..15.
- `BALL_SIZE`, 32: ball edge length in pixels.
- `PADDLE_W`, 100: paddle width in pixels.
- `X_MAX`, 608: largest legal ballXPos.
- `Y_MAX`, 620: largest legal ballYPos; must be ≥600 so the lost-ball condition is reachable.
- `SERVE_Y`, 400: ball Y while resting on the paddle.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `direction` in 2: from collision engine `directionOut`. bit1 = 1 means north (Y decreasing); bit0 = 1 means west (X decreasing).
- `lock` in 1: from collision engine; ball lost, sticky.
- `paddleXPos` in 10: paddle left edge.
- `launch` in 1: serve request; level or pulse, sampled each cycle.
- `ballXPos` out 10: ball left edge, registered.
- `ballYPos` out 10: ball top edge, registered.
- `ballDirUpdate` out 1: one-cycle strobe to collision engine, registered.
- `running` out 1: high in RUN state.
- `gameOver` out 1: high in OVER state.

## Operation
States are SERVE, RUN and OVER. Reset state is SERVE.

SERVE:
- Each cycle: ballXPos <= min(paddleXPos + PADDLE_W/2 − BALL_SIZE/2, X_MAX); ballYPos <= SERVE_Y.
- The tick counter is held at 0. ballDirUpdate stays low.
- launch=1 moves to RUN on the next edge.

RUN:
- The tick counter counts 0..TICK_DIV−1 and wraps.
- On the cycle the counter equals TICK_DIV−1 (move cycle), `direction` is sampled and each axis steps by STEP:
  - X west: x < STEP → 0, else x − STEP.
  - X east: x + STEP > X_MAX → X_MAX, else x + STEP.
  - Y north: y < STEP → 0, else y − STEP.
  - Y south: y + STEP > Y_MAX → Y_MAX, else y + STEP.
- Intermediate sums are 11 bits wide, so a sum near 1023 cannot wrap.
- ballDirUpdate is asserted on the cycle after the move cycle, and only then.
- launch is ignored.

OVER:
- Entered from any state on any cycle with lock=1; lock has priority over launch and over a move.
- Position is frozen and ballDirUpdate is held low.
- OVER is left only by rst.

Simultaneous events:
- lock=1 on the move cycle: the step is suppressed and the state goes to OVER.
- lock=1 on the strobe cycle: the already-registered strobe still completes that cycle.
- rst has priority over everything.

Reset values:
- State SERVE, counter 0.
- ballXPos=0, ballYPos=SERVE_Y.
- ballDirUpdate=0, running=0, gameOver=0.
- ballXPos follows the paddle from the first cycle after reset.

## Timing
- rst high at edge E: all outputs take their reset values at E.
- launch seen at edge E: running=1 after E. The first move cycle is TICK_DIV−1 cycles later, and its new position is visible after that edge.
- Move at edge M: the new position is visible after M; ballDirUpdate=1 for the cycle between M+1 and M+2.
- The collision engine updates direction at the M+2 edge. TICK_DIV ≥ 4 guarantees the next move samples the updated direction.
- Steady state: exactly one strobe per TICK_DIV cycles.
- running and gameOver are registered decodes of state; they change on the same edge as the state.

## Test plan
- Reset, then paddleXPos=200 held 3 cycles → ballXPos=234, ballYPos=400, running=0, no strobe.
- TICK_DIV=4, STEP=2, launch from x=234, y=400, direction=10 (NE) → after the first move x=236, y=398. Strobe appears 1 cycle after the move, then repeats every 4 cycles.
- Start from x=1, direction=01 (SV), STEP=2 → x clamps to 0 and y increases by 2. With x=607 and direction east → x clamps to X_MAX=608.
- lock asserted on the move cycle → position unchanged, gameOver=1, no further strobes for 100 cycles; a later launch has no effect.
- rst asserted mid-RUN, 2 cycles before a move → no move and no strobe. State returns to SERVE with y=400 and the counter restarted.
- Closed-loop: instantiate with the collision engine, TICK_DIV=4, paddle at 0, launch → ball reaches y≤3, direction bit1 flips, and y increases on the subsequent moves.

Source files
------------

// File: rtl/ball_motion_engine.sv
// Ball position stepper with serve-on-paddle, periodic motion ticks and lost-ball freeze.
// Emits a one-cycle direction-update strobe to the collision engine after every move.
module ball_motion_engine #(
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned STEP      = 2,
  parameter int unsigned BALL_SIZE = 32,
  parameter int unsigned PADDLE_W  = 100,
  parameter int unsigned X_MAX     = 608,
  parameter int unsigned Y_MAX     = 620,
  parameter int unsigned SERVE_Y   = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] direction,
  input  logic       lock,
  input  logic [9:0] paddleXPos,
  input  logic       launch,
  output logic [9:0] ballXPos,
  output logic [9:0] ballYPos,
  output logic       ballDirUpdate,
  output logic       running,
  output logic       gameOver
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned POS_W = 10;
  localparam int unsigned SUM_W = 11;
  localparam logic [SUM_W-1:0] SERVE_OFF = SUM_W'(PADDLE_W / 2) - SUM_W'(BALL_SIZE / 2);

  typedef enum logic [1:0] {SERVE, RUN, OVER} state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   tickCnt, cntNext;
  logic [POS_W-1:0]   xNext, yNext;
  logic               movedQ, movedNext;
  logic               strobeNext;
  logic               moveCycle;
  logic [SUM_W-1:0]   serveSum, xSum, ySum;
  logic [POS_W-1:0]   serveX, stepX, stepY;

  // Saturating per-axis step; sums carry an extra bit so they cannot wrap.
  always_comb begin
    serveSum = {1'b0, paddleXPos} + SERVE_OFF;
    serveX   = (serveSum > SUM_W'(X_MAX)) ? POS_W'(X_MAX) : serveSum[POS_W-1:0];
    xSum     = {1'b0, ballXPos} + SUM_W'(STEP);
    ySum     = {1'b0, ballYPos} + SUM_W'(STEP);
    if (direction[0])
      stepX = (ballXPos < POS_W'(STEP)) ? '0 : ballXPos - POS_W'(STEP);
    else
      stepX = (xSum > SUM_W'(X_MAX)) ? POS_W'(X_MAX) : xSum[POS_W-1:0];
    if (direction[1])
      stepY = (ballYPos < POS_W'(STEP)) ? '0 : ballYPos - POS_W'(STEP);
    else
      stepY = (ySum > SUM_W'(Y_MAX)) ? POS_W'(Y_MAX) : ySum[POS_W-1:0];
  end

  assign moveCycle = (tickCnt == CNT_W'(TICK_DIV - 1));

  // Next-state and next-output logic; lock overrides everything except reset.
  always_comb begin
    stateNext  = state;
    cntNext    = tickCnt;
    xNext      = ballXPos;
    yNext      = ballYPos;
    movedNext  = 1'b0;
    strobeNext = 1'b0;
    case (state)
      SERVE: begin
        xNext   = serveX;
        yNext   = POS_W'(SERVE_Y);
        cntNext = '0;
        if (launch) stateNext = RUN;
      end
      RUN: begin
        cntNext    = moveCycle ? '0 : tickCnt + CNT_W'(1);
        strobeNext = movedQ;
        if (moveCycle) begin
          xNext     = stepX;
          yNext     = stepY;
          movedNext = 1'b1;
        end
      end
      default: cntNext = '0;
    endcase
    if (lock) begin
      stateNext  = OVER;
      cntNext    = '0;
      xNext      = ballXPos;
      yNext      = ballYPos;
      movedNext  = 1'b0;
      strobeNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SERVE;
      tickCnt       <= '0;
      ballXPos      <= '0;
      ballYPos      <= POS_W'(SERVE_Y);
      movedQ        <= 1'b0;
      ballDirUpdate <= 1'b0;
      running       <= 1'b0;
      gameOver      <= 1'b0;
    end else begin
      state         <= stateNext;
      tickCnt       <= cntNext;
      ballXPos      <= xNext;
      ballYPos      <= yNext;
      movedQ        <= movedNext;
      ballDirUpdate <= strobeNext;
      running       <= (stateNext == RUN);
      gameOver      <= (stateNext == OVER);
    end
  end

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: directed scenarios plus randomized play against a
// tick-count based reference model and a small behavioural collision responder.
module tb_ball_motion_engine;

  localparam int TD = 4, ST = 2, XMAX = 608, YMAX = 620, SERVEY = 400, OFF = 34;

  logic       clk = 1'b0;
  logic       rst, lock, launch;
  logic [1:0] direction;
  logic [9:0] paddleXPos;
  logic [9:0] ballXPos, ballYPos;
  logic       ballDirUpdate, running, gameOver;
  logic [22:0] obs;

  int total = 0, bad = 0;
  int mMode, mX, mY, mN;
  bit mStrobe;

  always #5 clk = ~clk;

  ball_motion_engine #(.TICK_DIV(TD), .STEP(ST)) dut (
    .clk(clk), .rst(rst), .direction(direction), .lock(lock),
    .paddleXPos(paddleXPos), .launch(launch), .ballXPos(ballXPos),
    .ballYPos(ballYPos), .ballDirUpdate(ballDirUpdate), .running(running),
    .gameOver(gameOver)
  );

  assign obs = {ballXPos, ballYPos, ballDirUpdate, running, gameOver};

  function automatic int stepAxis(int v, bit neg, int hi);
    if (neg) return (v < ST) ? 0 : v - ST;
    return (v + ST > hi) ? hi : v + ST;
  endfunction

  function automatic logic [22:0] expv();
    return {10'(mX), 10'(mY), mStrobe, mMode == 1, mMode == 2};
  endfunction

  // Mode 0 serve, 1 run, 2 over; mN counts edges since launch, moves land on multiples of TD.
  task automatic cycle();
    if (rst) begin
      mMode = 0; mX = 0; mY = SERVEY; mN = 0; mStrobe = 0;
    end else if (lock) begin
      mMode = 2; mStrobe = 0;
    end else if (mMode == 0) begin
      mX = (int'(paddleXPos) + OFF > XMAX) ? XMAX : int'(paddleXPos) + OFF;
      mY = SERVEY; mStrobe = 0;
      if (launch) begin mMode = 1; mN = 0; end
    end else if (mMode == 1) begin
      mN++;
      mStrobe = (mN % TD == 1) && (mN > 1);
      if (mN % TD == 0) begin
        mX = stepAxis(mX, direction[0], XMAX);
        mY = stepAxis(mY, direction[1], YMAX);
      end
    end else mStrobe = 0;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1; lock = 0; launch = 0; cycle(); rst = 0;
  endtask

  task automatic test_reset();
    paddleXPos = 10'd200; direction = 2'b00;
    doReset();
    total++;
    if (obs !== {10'd0, 10'd400, 3'b000}) begin
      bad++; $display("FAIL reset_values got=%h want=%h", obs, {10'd0, 10'd400, 3'b000});
    end
    for (int i = 0; i < 3; i++) cycle();
    total++;
    if (obs !== {10'd234, 10'd400, 3'b000}) begin
      bad++; $display("FAIL serve_follow got=%h want=%h", obs, {10'd234, 10'd400, 3'b000});
    end
    paddleXPos = 10'd1000; cycle();
    total++;
    if (ballXPos !== 10'd608) begin
      bad++; $display("FAIL serve_clamp got=%0d want=608", ballXPos);
    end
  endtask

  task automatic test_first_move();
    paddleXPos = 10'd200; direction = 2'b10;
    doReset(); cycle();
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < TD; i++) begin
      cycle(); total++;
      if (obs !== expv()) begin bad++; $display("FAIL first_move_seq got=%h want=%h", obs, expv()); end
    end
    total++;
    if (ballXPos !== 10'd236 || ballYPos !== 10'd398) begin
      bad++; $display("FAIL first_move_pos got=%0d,%0d want=236,398", ballXPos, ballYPos);
    end
    for (int i = 0; i < 3 * TD; i++) begin
      cycle(); total++;
      if (ballDirUpdate !== ((i % TD) == 0)) begin
        bad++; $display("FAIL strobe_period i=%0d got=%b want=%b", i, ballDirUpdate, (i % TD) == 0);
      end
    end
  endtask

  task automatic test_clamp();
    paddleXPos = 10'd1; direction = 2'b01;
    doReset(); cycle();
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < 20 * TD; i++) begin
      cycle(); total++;
      if (obs !== expv()) begin bad++; $display("FAIL clamp_west_seq got=%h want=%h", obs, expv()); end
    end
    total++;
    if (ballXPos !== 10'd0 || ballYPos !== 10'd440) begin
      bad++; $display("FAIL clamp_west got=%0d,%0d want=0,440", ballXPos, ballYPos);
    end
    paddleXPos = 10'd573; direction = 2'b00;
    doReset(); cycle();
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < 2 * TD; i++) cycle();
    total++;
    if (ballXPos !== 10'd608 || ballYPos !== 10'd404) begin
      bad++; $display("FAIL clamp_east got=%0d,%0d want=608,404", ballXPos, ballYPos);
    end
  endtask

  task automatic test_lock();
    logic [9:0] sx, sy;
    int strobes = 0;
    paddleXPos = 10'd300; direction = 2'b11;
    doReset(); cycle();
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < 100 && mN != 2 * TD - 1; i++) cycle();
    sx = ballXPos; sy = ballYPos;
    lock = 1; cycle();
    total++;
    if (ballXPos !== sx || ballYPos !== sy || gameOver !== 1'b1 || running !== 1'b0) begin
      bad++; $display("FAIL lock_on_move got=%0d,%0d,go=%b want=%0d,%0d,go=1", ballXPos, ballYPos, gameOver, sx, sy);
    end
    for (int i = 0; i < 100; i++) begin
      launch = 1'($urandom); direction = 2'($urandom);
      if (i == 10) lock = 0;
      cycle();
      if (ballDirUpdate) strobes++;
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL over_hold got=%h want=%h", obs, expv()); end
    end
    total++;
    if (strobes != 0) begin bad++; $display("FAIL over_strobes got=%0d want=0", strobes); end
    launch = 0;
  endtask

  task automatic test_reset_midrun();
    paddleXPos = 10'd120; direction = 2'b10;
    doReset(); cycle();
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < 100 && mN != 2 * TD - 2; i++) cycle();
    rst = 1; cycle(); rst = 0;
    total++;
    if (ballYPos !== 10'd400 || running !== 1'b0 || ballDirUpdate !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got y=%0d run=%b stb=%b want 400,0,0", ballYPos, running, ballDirUpdate);
    end
    for (int i = 0; i < 2 * TD; i++) begin
      cycle(); total++;
      if (obs !== expv()) begin bad++; $display("FAIL midrun_serve got=%h want=%h", obs, expv()); end
    end
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      cycle(); total++;
      if (obs !== expv()) begin bad++; $display("FAIL midrun_relaunch got=%h want=%h", obs, expv()); end
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 8; ep++) begin
      paddleXPos = 10'($urandom); direction = 2'($urandom);
      doReset();
      for (int i = 0; i < int'($urandom_range(5, 1)); i++) begin
        paddleXPos = 10'($urandom); cycle(); total++;
        if (obs !== expv()) begin bad++; $display("FAIL rand_serve ep=%0d got=%h want=%h", ep, obs, expv()); end
      end
      launch = 1; cycle(); launch = 0;
      for (int i = 0; i < int'($urandom_range(120, 30)); i++) begin
        direction = 2'($urandom); launch = 1'($urandom); paddleXPos = 10'($urandom);
        rst = ($urandom_range(60, 0) == 0);
        cycle(); rst = 0; total++;
        if (obs !== expv()) begin bad++; $display("FAIL rand_run ep=%0d got=%h want=%h", ep, obs, expv()); end
        if (mMode == 0 && !rst) begin launch = 1; end
      end
      launch = 0;
    end
  endtask

  task automatic test_closed_loop();
    bit flipped = 0;
    int yAtFlip = 0, flipN = 0;
    paddleXPos = 10'd0; direction = 2'b10;
    doReset(); cycle();
    launch = 1; cycle(); launch = 0;
    for (int i = 0; i < 3000 && !(flipped && mN >= flipN + 3 * TD); i++) begin
      cycle(); total++;
      if (obs !== expv()) begin bad++; $display("FAIL loop_seq got=%h want=%h", obs, expv()); end
      if (ballDirUpdate) begin
        if (direction[1] && ballYPos <= 10'd3) begin
          direction[1] = 1'b0; flipped = 1; yAtFlip = int'(ballYPos); flipN = mN;
        end
        if (!direction[0] && ballXPos >= 10'(XMAX)) direction[0] = 1'b1;
        else if (direction[0] && ballXPos == 10'd0) direction[0] = 1'b0;
      end
    end
    total++;
    if (!flipped) begin
      bad++; $display("FAIL loop_no_bounce got y=%0d want y<=3 reached", ballYPos);
    end else if (int'(ballYPos) != yAtFlip + 3 * ST) begin
      bad++; $display("FAIL loop_rebound got y=%0d want=%0d", ballYPos, yAtFlip + 3 * ST);
    end
  endtask

  initial begin
    rst = 1; lock = 0; launch = 0; direction = 2'b00; paddleXPos = 10'd0;
    test_reset();
    test_first_move();
    test_clamp();
    test_lock();
    test_reset_midrun();
    test_random();
    test_closed_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
